// File: rtl/topk_patch_sorter.sv
`default_nettype none
// ============================================================================
//  Module   : topk_patch_sorter
//  Purpose  : Keeps a running top-K list of per-patch weighted sums for one
//             frame and drains the K largest (patch_num, wtsum) pairs in
//             descending order once the frame's final patch has arrived.
//  Revision : 1.0  initial release
// ============================================================================
module topk_patch_sorter #(
   parameter  int FP_SIZE  = 32,
   parameter  int N_PATCH  = 1024,
   parameter  int K        = 8,
   localparam int c_PNUM_W = (N_PATCH > 1) ? $clog2(N_PATCH) : 1,
   localparam int c_RANK_W = (K > 1) ? $clog2(K) : 1
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                in_valid,
   input  logic [FP_SIZE-1:0]  in_wtsum,
   input  logic                in_last,
   output logic                in_ready,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [FP_SIZE-1:0]  out_wtsum,
   output logic [c_PNUM_W-1:0] out_patch_num,
   output logic [c_RANK_W-1:0] out_rank,
   output logic                out_last,
   output logic                error
);

   typedef enum logic [1:0] {
      S_CLEAR   = 2'd0,
      S_COLLECT = 2'd1,
      S_DRAIN   = 2'd2,
      S_ERROR   = 2'd3
   } state_t;

   state_t                state_q;
   logic [c_PNUM_W-1:0]   cnt_q;
   logic [c_RANK_W-1:0]   idx_q;
   logic                  in_ready_q;
   logic                  out_valid_q;
   logic                  error_q;

   // Slot 0 holds the largest value; valid slots are always contiguous from 0.
   logic [FP_SIZE-1:0]    val_q [K];
   logic [FP_SIZE-1:0]    val_d [K];
   logic [c_PNUM_W-1:0]   num_q [K];
   logic [c_PNUM_W-1:0]   num_d [K];
   logic [K-1:0]          vld_q;
   logic [K-1:0]          vld_d;

   logic [K-1:0]          w_disp;
   logic [FP_SIZE-1:0]    w_new_key;
   logic                  w_accept;
   logic                  w_overrun;
   logic                  w_insert;
   logic                  w_out_xfer;
   logic                  w_next_vld;
   logic                  w_last;

   // Maps an IEEE-754 pattern to an unsigned key that orders like the float
   // value; -0.0 lands just below +0.0.
   function automatic logic [FP_SIZE-1:0] f_key(input logic [FP_SIZE-1:0] v);
      if (v[FP_SIZE-1]) begin
         return ~v;
      end
      return {1'b1, v[FP_SIZE-2:0]};
   endfunction

   assign w_accept   = in_valid && in_ready_q;
   assign w_overrun  = (cnt_q == c_PNUM_W'(N_PATCH - 1)) && !in_last;
   assign w_insert   = w_accept && !w_overrun;
   assign w_out_xfer = out_valid_q && out_ready;

   // Parallel insertion: every slot decides in one cycle whether it keeps its
   // entry, takes the new value, or inherits its upper neighbour.
   always_comb begin
      w_new_key = f_key(in_wtsum);
      for (int i = 0; i < K; i++) begin
         w_disp[i] = !vld_q[i] || (w_new_key > f_key(val_q[i]));
      end
      val_d[0] = w_disp[0] ? in_wtsum : val_q[0];
      num_d[0] = w_disp[0] ? cnt_q    : num_q[0];
      vld_d[0] = vld_q[0] | w_disp[0];
      for (int i = 1; i < K; i++) begin
         if (w_disp[i-1]) begin
            val_d[i] = val_q[i-1];
            num_d[i] = num_q[i-1];
            vld_d[i] = vld_q[i-1];
         end else if (w_disp[i]) begin
            val_d[i] = in_wtsum;
            num_d[i] = cnt_q;
            vld_d[i] = 1'b1;
         end else begin
            val_d[i] = val_q[i];
            num_d[i] = num_q[i];
            vld_d[i] = vld_q[i];
         end
      end
   end

   // Drain read-out: select the slot at the drain index and look one slot
   // ahead to decide whether this entry is the frame's last.
   always_comb begin
      out_wtsum     = '0;
      out_patch_num = '0;
      w_next_vld    = 1'b0;
      for (int i = 0; i < K; i++) begin
         if (idx_q == c_RANK_W'(i)) begin
            out_wtsum     = val_q[i];
            out_patch_num = num_q[i];
         end
      end
      for (int i = 0; i < K - 1; i++) begin
         if (idx_q == c_RANK_W'(i)) begin
            w_next_vld = vld_q[i+1];
         end
      end
      w_last = (idx_q == c_RANK_W'(K - 1)) || !w_next_vld;
   end

   // Slot valid bits are wiped on reset and at the start of every frame.
   always_ff @(posedge CLK) begin
      if (RESET || (state_q == S_CLEAR)) begin
         vld_q <= '0;
      end else if (w_insert) begin
         vld_q <= vld_d;
      end
   end

   // Slot payloads only matter while their valid bit is set, so no reset.
   always_ff @(posedge CLK) begin
      if (w_insert) begin
         for (int i = 0; i < K; i++) begin
            val_q[i] <= val_d[i];
            num_q[i] <= num_d[i];
         end
      end
   end

   // Frame control: clear, collect patches, drain sorted entries, or latch an
   // overrun until reset.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= S_CLEAR;
         cnt_q       <= '0;
         idx_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         case (state_q)
            S_CLEAR: begin
               cnt_q      <= '0;
               idx_q      <= '0;
               in_ready_q <= 1'b1;
               state_q    <= S_COLLECT;
            end
            S_COLLECT: begin
               if (w_accept) begin
                  if (w_overrun) begin
                     state_q    <= S_ERROR;
                     error_q    <= 1'b1;
                     in_ready_q <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q + c_PNUM_W'(1);
                     if (in_last) begin
                        state_q     <= S_DRAIN;
                        idx_q       <= '0;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                     end
                  end
               end
            end
            S_DRAIN: begin
               if (w_out_xfer) begin
                  if (w_last) begin
                     state_q     <= S_CLEAR;
                     out_valid_q <= 1'b0;
                  end else begin
                     idx_q <= idx_q + c_RANK_W'(1);
                  end
               end
            end
            S_ERROR: begin
               in_ready_q  <= 1'b0;
               out_valid_q <= 1'b0;
               error_q     <= 1'b1;
            end
            default: begin
               state_q <= S_CLEAR;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_rank  = idx_q;
   assign out_last  = out_valid_q && w_last;
   assign error     = error_q;

endmodule
`default_nettype wire

// File: tb/tb_topk_patch_sorter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_topk_patch_sorter
//  Purpose  : Self-checking bench for topk_patch_sorter (K=4, N_PATCH=16).
//  Revision : 1.0  initial release
// ============================================================================
module tb_topk_patch_sorter;

   localparam int c_FP = 32;
   localparam int c_NP = 16;
   localparam int c_K  = 4;

   logic            CLK = 1'b0;
   logic            RESET;
   logic            in_valid;
   logic [c_FP-1:0] in_wtsum;
   logic            in_last;
   logic            in_ready;
   logic            out_valid;
   logic            out_ready;
   logic [c_FP-1:0] out_wtsum;
   logic [3:0]      out_patch_num;
   logic [1:0]      out_rank;
   logic            out_last;
   logic            error;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] frame_q [$];
   logic [31:0] exp_v   [$];
   int          exp_p   [$];

   topk_patch_sorter #(.FP_SIZE(c_FP), .N_PATCH(c_NP), .K(c_K)) u_dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .in_valid      (in_valid),
      .in_wtsum      (in_wtsum),
      .in_last       (in_last),
      .in_ready      (in_ready),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_wtsum     (out_wtsum),
      .out_patch_num (out_patch_num),
      .out_rank      (out_rank),
      .out_last      (out_last),
      .error         (error)
   );

   always #5 CLK = ~CLK;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Float ordering by sign and magnitude: any positive beats any negative,
   // larger magnitude wins among positives, smaller among negatives.
   function automatic bit gt(input logic [31:0] a, input logic [31:0] b);
      if (a[31] != b[31]) return !a[31];
      if (!a[31]) return a[30:0] > b[30:0];
      return a[30:0] < b[30:0];
   endfunction

   // Expected drain: repeatedly pick the largest unused entry; the earliest
   // arrival wins a tie because only a strictly larger value replaces it.
   task automatic build_expected();
      bit used [16];
      int m;
      exp_v.delete();
      exp_p.delete();
      for (int i = 0; i < 16; i++) used[i] = 1'b0;
      m = (frame_q.size() < c_K) ? frame_q.size() : c_K;
      for (int r = 0; r < m; r++) begin
         int best = -1;
         for (int i = 0; i < frame_q.size(); i++) begin
            if (!used[i] && (best < 0 || gt(frame_q[i], frame_q[best]))) best = i;
         end
         used[best] = 1'b1;
         exp_v.push_back(frame_q[best]);
         exp_p.push_back(best);
      end
   endtask

   function automatic logic [31:0] rand_val();
      case ($urandom_range(0, 7))
         0: return 32'h3F80_0000;
         1: return 32'h40A0_0000;
         2: return 32'hC000_0000;
         3: return 32'h0000_0000;
         4: return 32'h8000_0000;
         5: return 32'h4040_0000;
         default: return $urandom;
      endcase
   endfunction

   task automatic do_reset();
      RESET = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      repeat (2) @(negedge CLK);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_error", error, 0);
      RESET = 1'b0;
      @(negedge CLK);
      check("post_rst_in_ready", in_ready, 1);
   endtask

   // Starts and ends just after a falling edge; waits (bounded) for in_ready.
   task automatic push(input logic [31:0] v, input logic last);
      int guard = 0;
      in_valid = 1'b1; in_wtsum = v; in_last = last;
      while (!in_ready && guard < 50) begin
         @(negedge CLK);
         guard++;
      end
      check("in_ready_wait", in_ready, 1);
      @(negedge CLK);
      in_valid = 1'b0; in_last = 1'b0; in_wtsum = $urandom;
   endtask

   task automatic send_frame(input bit gaps);
      for (int i = 0; i < frame_q.size(); i++) begin
         if (gaps && $urandom_range(0, 3) == 0) @(negedge CLK);
         push(frame_q[i], i == frame_q.size() - 1);
      end
      check("first_out_valid", out_valid, 1);
      check("first_out_rank", out_rank, 0);
      check("in_ready_in_drain", in_ready, 0);
   endtask

   task automatic drain(input int stall_rank, input int stall_len);
      build_expected();
      for (int j = 0; j < exp_v.size(); j++) begin
         int guard = 0;
         int stalls;
         while (!out_valid && guard < 50) begin
            @(negedge CLK);
            guard++;
         end
         check($sformatf("out_valid_r%0d", j), out_valid, 1);
         check($sformatf("wtsum_r%0d", j), out_wtsum, exp_v[j]);
         check($sformatf("patch_r%0d", j), out_patch_num, exp_p[j]);
         check($sformatf("rank_r%0d", j), out_rank, j);
         check($sformatf("last_r%0d", j), out_last, j == exp_v.size() - 1);
         check($sformatf("in_ready_r%0d", j), in_ready, 0);
         stalls = (j == stall_rank) ? stall_len : $urandom_range(0, 2);
         out_ready = 1'b0;
         repeat (stalls) begin
            @(negedge CLK);
            check("hold_valid", out_valid, 1);
            check("hold_wtsum", out_wtsum, exp_v[j]);
            check("hold_patch", out_patch_num, exp_p[j]);
            check("hold_rank", out_rank, j);
            check("hold_in_ready", in_ready, 0);
         end
         out_ready = 1'b1;
         @(negedge CLK);
         out_ready = 1'b0;
      end
      check("post_drain_valid", out_valid, 0);
      check("post_drain_in_ready", in_ready, 0);
      @(negedge CLK);
      check("next_frame_in_ready", in_ready, 1);
   endtask

   initial begin
      RESET = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_wtsum = '0; out_ready = 1'b0;
      do_reset();

      // Mixed frame with a tie on 5.0.
      frame_q = '{32'h3F80_0000, 32'h40A0_0000, 32'h4040_0000,
                  32'h40A0_0000, 32'hC000_0000, 32'h4080_0000};
      send_frame(1'b0);
      drain(-1, 0);

      // Signed zeros: +0.0 ranks above -0.0.
      frame_q = '{32'h8000_0000, 32'h0000_0000};
      send_frame(1'b0);
      drain(-1, 0);

      // Same mixed frame with a long consumer stall on rank 1.
      frame_q = '{32'h3F80_0000, 32'h40A0_0000, 32'h4040_0000,
                  32'h40A0_0000, 32'hC000_0000, 32'h4080_0000};
      send_frame(1'b0);
      drain(1, 5);

      // Back-to-back frame: nothing from the previous frame may survive.
      frame_q = '{32'h40E0_0000, 32'h40C0_0000};
      send_frame(1'b0);
      drain(-1, 0);

      // Random frames, lengths 1..N_PATCH (a full frame ending with last).
      for (int f = 0; f < 20; f++) begin
         int len = $urandom_range(1, c_NP);
         frame_q.delete();
         for (int i = 0; i < len; i++) frame_q.push_back(rand_val());
         send_frame(1'b1);
         drain(-1, 0);
      end

      // Reset while rank 1 is presented.
      frame_q.delete();
      for (int i = 0; i < 6; i++) frame_q.push_back(rand_val());
      send_frame(1'b0);
      build_expected();
      check("mid_rst_r0_wtsum", out_wtsum, exp_v[0]);
      out_ready = 1'b1;
      @(negedge CLK);
      out_ready = 1'b0;
      check("mid_rst_rank1", out_rank, 1);
      RESET = 1'b1;
      @(negedge CLK);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_error", error, 0);
      check("mid_rst_in_ready", in_ready, 0);
      RESET = 1'b0;
      @(negedge CLK);
      check("mid_rst_ready_back", in_ready, 1);
      frame_q.delete();
      for (int i = 0; i < 5; i++) frame_q.push_back(rand_val());
      send_frame(1'b1);
      drain(-1, 0);

      // Overrun: N_PATCH accepts without last.
      for (int i = 0; i < c_NP; i++) push(rand_val(), 1'b0);
      check("ovr_error", error, 1);
      check("ovr_in_ready", in_ready, 0);
      check("ovr_out_valid", out_valid, 0);
      in_valid = 1'b1; in_last = 1'b1;
      repeat (4) begin
         @(negedge CLK);
         check("ovr_sticky_error", error, 1);
         check("ovr_sticky_in_ready", in_ready, 0);
         check("ovr_sticky_out_valid", out_valid, 0);
      end
      in_valid = 1'b0; in_last = 1'b0;
      do_reset();

      frame_q.delete();
      for (int i = 0; i < 9; i++) frame_q.push_back(rand_val());
      send_frame(1'b1);
      drain(2, 3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
